// File: rtl/ff_autoplay_pkg.sv
// Shared widths and state encoding for the autoplay scheduler.
package ff_autoplay_pkg;
  localparam int unsigned STATE_W = 3;
  localparam int unsigned MS_W    = 16;

  typedef enum logic [STATE_W-1:0] {
    S_OFF     = 3'd0,
    S_BOOT    = 3'd1,
    S_COIN    = 3'd2,
    S_GAP1    = 3'd3,
    S_START   = 3'd4,
    S_GAP2    = 3'd5,
    S_THR_ON  = 3'd6,
    S_THR_OFF = 3'd7
  } state_e;
endpackage

// File: rtl/ff_autoplay_seq_if.sv
// Control and request signals between the board glue and the autoplay scheduler.
import ff_autoplay_pkg::*;

interface ff_autoplay_seq_if;
  logic               enable;
  logic               manual_active;
  logic               auto_coin_n;
  logic               auto_start_n;
  logic               auto_throw_n;
  logic               busy;
  logic [STATE_W-1:0] state_o;

  modport master (
    output enable, manual_active,
    input  auto_coin_n, auto_start_n, auto_throw_n, busy, state_o
  );

  modport slave (
    input  enable, manual_active,
    output auto_coin_n, auto_start_n, auto_throw_n, busy, state_o
  );
endinterface

// File: rtl/ff_ms_timer.sv
// Millisecond timebase: prescaler producing a tick, and a tick counter, both clearable.
import ff_autoplay_pkg::*;

module ff_ms_timer #(
  parameter int unsigned TICK_DIV = 12000
) (
  input  logic            clk12m,
  input  logic            reset,
  input  logic            clear,
  output logic            tick,
  output logic [MS_W-1:0] ms_count
);
  localparam int unsigned PRESC_W = 16;

  logic [PRESC_W-1:0] prescaler;

  assign tick = (prescaler == PRESC_W'(TICK_DIV - 1));

  always_ff @(posedge clk12m) begin
    if (reset || clear) begin
      prescaler <= '0;
      ms_count  <= '0;
    end else if (tick) begin
      prescaler <= '0;
      ms_count  <= ms_count + MS_W'(1);
    end else begin
      prescaler <= prescaler + PRESC_W'(1);
    end
  end
endmodule

// File: rtl/ff_autoplay_seq.sv
// Attract-mode input scheduler: timed coin/start sequence followed by periodic throws,
// aborted by any manual button activity until the enable switch is cycled.
import ff_autoplay_pkg::*;

module ff_autoplay_seq #(
  parameter int unsigned TICK_DIV        = 12000,
  parameter int unsigned BOOT_MS         = 2000,
  parameter int unsigned PULSE_MS        = 100,
  parameter int unsigned GAP_MS          = 1000,
  parameter int unsigned THROW_MS        = 50,
  parameter int unsigned THROW_PERIOD_MS = 250
) (
  input  logic              clk12m,
  input  logic              reset,
  ff_autoplay_seq_if.slave  io
);
  localparam logic [MS_W-1:0] BOOT_LAST  = MS_W'(BOOT_MS - 1);
  localparam logic [MS_W-1:0] PULSE_LAST = MS_W'(PULSE_MS - 1);
  localparam logic [MS_W-1:0] GAP_LAST   = MS_W'(GAP_MS - 1);
  localparam logic [MS_W-1:0] THR_LAST   = MS_W'(THROW_MS - 1);
  localparam logic [MS_W-1:0] REST_LAST  = MS_W'(THROW_PERIOD_MS - THROW_MS - 1);

  state_e          state_q, state_d;
  logic            abort_q, abort_d;
  logic            tick;
  logic [MS_W-1:0] ms_count;
  logic            timer_clear;

  // Restarting the timebase on every state change makes each dwell exactly dur*TICK_DIV cycles.
  assign timer_clear = (state_d != state_q);

  ff_ms_timer #(.TICK_DIV(TICK_DIV)) u_timer (
    .clk12m   (clk12m),
    .reset    (reset),
    .clear    (timer_clear),
    .tick     (tick),
    .ms_count (ms_count)
  );

  always_comb begin
    state_d = state_q;
    abort_d = abort_q;
    if (!io.enable) begin
      state_d = S_OFF;
      abort_d = 1'b0;
    end else if (io.manual_active) begin
      state_d = S_OFF;
      abort_d = 1'b1;
    end else begin
      case (state_q)
        S_OFF:     if (!abort_q)                     state_d = S_BOOT;
        S_BOOT:    if (tick && ms_count == BOOT_LAST)  state_d = S_COIN;
        S_COIN:    if (tick && ms_count == PULSE_LAST) state_d = S_GAP1;
        S_GAP1:    if (tick && ms_count == GAP_LAST)   state_d = S_START;
        S_START:   if (tick && ms_count == PULSE_LAST) state_d = S_GAP2;
        S_GAP2:    if (tick && ms_count == GAP_LAST)   state_d = S_THR_ON;
        S_THR_ON:  if (tick && ms_count == THR_LAST)   state_d = S_THR_OFF;
        S_THR_OFF: if (tick && ms_count == REST_LAST)  state_d = S_THR_ON;
        default:                                     state_d = S_OFF;
      endcase
    end
  end

  always_ff @(posedge clk12m) begin
    if (reset) begin
      state_q <= S_OFF;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      abort_q <= abort_d;
    end
  end

  assign io.auto_coin_n  = (state_q != S_COIN);
  assign io.auto_start_n = (state_q != S_START);
  assign io.auto_throw_n = (state_q != S_THR_ON);
  assign io.busy         = (state_q != S_OFF);
  assign io.state_o      = state_q;
endmodule

// File: tb/tb_ff_autoplay_seq.sv
// Bench for ff_autoplay_seq: directed scenarios plus random enable/manual/reset traffic
// checked cycle by cycle against a countdown-style reference of the schedule.
module tb_ff_autoplay_seq;
  localparam int unsigned TD    = 4;
  localparam int unsigned BOOT  = 3;
  localparam int unsigned PULSE = 2;
  localparam int unsigned GAP   = 2;
  localparam int unsigned THR   = 1;
  localparam int unsigned PER   = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_mis = 0;

  // reference: phase index, cycles spent in phase, abort flag
  int   m_st  = 0;
  int   m_cnt = 0;
  bit   m_ab  = 1'b0;

  ff_autoplay_seq_if bus();

  ff_autoplay_seq #(
    .TICK_DIV(TD), .BOOT_MS(BOOT), .PULSE_MS(PULSE),
    .GAP_MS(GAP), .THROW_MS(THR), .THROW_PERIOD_MS(PER)
  ) dut (
    .clk12m (clk),
    .reset  (rst),
    .io     (bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int dur_cyc(input int st);
    case (st)
      1:       return BOOT * TD;
      2, 4:    return PULSE * TD;
      3, 5:    return GAP * TD;
      6:       return THR * TD;
      7:       return (PER - THR) * TD;
      default: return 0;
    endcase
  endfunction

  function automatic void model_step();
    if (rst) begin
      m_st = 0; m_cnt = 0; m_ab = 1'b0;
    end else if (!bus.enable) begin
      m_st = 0; m_cnt = 0; m_ab = 1'b0;
    end else if (bus.manual_active) begin
      m_st = 0; m_cnt = 0; m_ab = 1'b1;
    end else if (m_st == 0) begin
      if (!m_ab) begin m_st = 1; m_cnt = 0; end
    end else begin
      m_cnt++;
      if (m_cnt == dur_cyc(m_st)) begin
        m_st  = (m_st == 7) ? 6 : m_st + 1;
        m_cnt = 0;
      end
    end
  endfunction

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check_eq("state", int'(bus.state_o), m_st);
    check_eq("coin_n", int'(bus.auto_coin_n), (m_st == 2) ? 0 : 1);
    check_eq("start_n", int'(bus.auto_start_n), (m_st == 4) ? 0 : 1);
    check_eq("throw_n", int'(bus.auto_throw_n), (m_st == 6) ? 0 : 1);
    check_eq("busy", int'(bus.busy), (m_st != 0) ? 1 : 0);
  endtask

  // Measures how long the DUT stays in st, given one cycle in st already observed.
  task automatic dwell(input int st, input int exp_len, input string tag);
    int n = 1;
    while (n < 1000) begin
      cycle();
      if (int'(bus.state_o) == st) n++;
      else break;
    end
    check_eq(tag, n, exp_len);
  endtask

  task automatic run_until(input int target, input int budget);
    int k = 0;
    while (m_st != target && k < budget) begin
      cycle();
      k++;
    end
    check_eq("reach", int'(bus.state_o), target);
  endtask

  initial begin
    int throw_lows;
    bus.enable        = 1'b0;
    bus.manual_active = 1'b0;

    // 1: reset for 3 cycles, enable raised as reset drops
    repeat (3) cycle();
    check_eq("rst_state", int'(bus.state_o), 0);
    check_eq("rst_busy", int'(bus.busy), 0);
    rst = 1'b0;
    bus.enable = 1'b1;
    cycle();
    check_eq("boot_entry", int'(bus.state_o), 1);
    dwell(1, 12, "boot_len");
    dwell(2, 8, "coin_len");
    // 2: rest of the sequence and five throw periods
    dwell(3, 8, "gap1_len");
    dwell(4, 8, "start_len");
    dwell(5, 8, "gap2_len");
    for (int i = 0; i < 5; i++) begin
      dwell(6, 4, "thr_on_len");
      dwell(7, 8, "thr_off_len");
    end

    // 3: manual pulse during THR_ON latches the abort
    bus.manual_active = 1'b1;
    cycle();
    bus.manual_active = 1'b0;
    check_eq("abort_throw_n", int'(bus.auto_throw_n), 1);
    check_eq("abort_state", int'(bus.state_o), 0);
    repeat (100) cycle();
    check_eq("abort_hold", int'(bus.state_o), 0);
    bus.enable = 1'b0;
    cycle();
    bus.enable = 1'b1;
    cycle();
    check_eq("restart_boot", int'(bus.state_o), 1);

    // 4: enable dropped during START, then re-enabled
    run_until(4, 200);
    bus.enable = 1'b0;
    cycle();
    check_eq("drop_busy", int'(bus.busy), 0);
    check_eq("drop_start_n", int'(bus.auto_start_n), 1);
    bus.enable = 1'b1;
    cycle();
    dwell(1, 12, "reboot_len");

    // 5: reset pulse during COIN with enable held
    cycle();
    cycle();
    rst = 1'b1;
    cycle();
    check_eq("rst_coin_n", int'(bus.auto_coin_n), 1);
    rst = 1'b0;
    cycle();
    check_eq("rst_reboot", int'(bus.state_o), 1);
    dwell(1, 12, "rst_boot_len");

    // 6: manual press lands on the GAP2 exit tick
    run_until(5, 200);
    for (int k = 0; k < 100 && m_cnt != dur_cyc(5) - 1; k++) cycle();
    check_eq("gap2_last", m_cnt, dur_cyc(5) - 1);
    bus.manual_active = 1'b1;
    cycle();
    bus.manual_active = 1'b0;
    check_eq("coincide_state", int'(bus.state_o), 0);
    throw_lows = 0;
    for (int k = 0; k < 50; k++) begin
      cycle();
      if (bus.auto_throw_n == 1'b0) throw_lows++;
    end
    check_eq("coincide_no_throw", throw_lows, 0);

    // random traffic
    bus.enable = 1'b0;
    cycle();
    bus.enable = 1'b1;
    for (int k = 0; k < 4000; k++) begin
      cycle();
      if ($urandom_range(199) == 0) bus.enable = ~bus.enable;
      bus.manual_active = ($urandom_range(149) == 0);
      rst = ($urandom_range(499) == 0);
      if (bus.enable == 1'b0 && $urandom_range(9) == 0) bus.enable = 1'b1;
    end
    rst = 1'b0;
    bus.manual_active = 1'b0;
    cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
